// File: rtl/wasca_switches_ctrl.sv
// Avalon-MM switch controller: synchronised and debounced switch state,
// per-bit change capture with write-1-to-clear, an interrupt mask and a programmable debounce period.
module wasca_switches_ctrl #(
    parameter int WIDTH        = 3,
    parameter int DEBOUNCE_RST = 50000,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_EDGE   = 2'd2;
    localparam logic [1:0] ADDR_PERIOD = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edge_clr;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [31:0]      rd_mux;
    logic             wr_mask;
    logic             wr_edge;
    logic             wr_period;
    logic             unused_ok;

    assign wr_mask   = chipselect & write & (address == ADDR_MASK);
    assign wr_edge   = chipselect & write & (address == ADDR_EDGE);
    assign wr_period = chipselect & write & (address == ADDR_PERIOD);
    assign edge_clr  = wr_edge ? writedata[WIDTH-1:0] : '0;
    assign unused_ok = &{1'b0, writedata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // A period write restarts every in-flight debounce; period 0 bypasses the filter entirely.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else if (period == '0) begin
            stable <= sync2;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else if (wr_period) begin
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == period - CNT_W'(1)) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // New changes are OR-ed in after the clear so a coincident set survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d <= '0;
            edges    <= '0;
            mask     <= '0;
            period   <= CNT_W'(DEBOUNCE_RST);
            irq      <= 1'b0;
        end else begin
            stable_d <= stable;
            edges    <= (edges & ~edge_clr) | (stable ^ stable_d);
            irq      <= |(edges & mask);
            if (wr_mask)   mask   <= writedata[WIDTH-1:0];
            if (wr_period) period <= writedata[CNT_W-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:   rd_mux[WIDTH-1:0] = stable;
            ADDR_MASK:   rd_mux[WIDTH-1:0] = mask;
            ADDR_EDGE:   rd_mux[WIDTH-1:0] = edges;
            ADDR_PERIOD: rd_mux[CNT_W-1:0] = period;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

endmodule

// File: tb/tb_wasca_switches_ctrl.sv
// Self-checking bench for wasca_switches_ctrl: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the switch controller.
module tb_wasca_switches_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [2:0]  in_port = 3'b000;
    logic        irq;

    int errors = 0;
    int checks = 0;

    // Behavioural model state: pin pipeline, debounced value, run length of disagreement.
    logic [2:0]  m_s1, m_s2, m_stab, m_stab_d, m_edge, m_mask;
    logic [15:0] m_per;
    int          m_run [3];
    logic [31:0] m_rd;
    logic        m_irq;

    wasca_switches_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic m_reset();
        m_s1 = '0; m_s2 = '0; m_stab = '0; m_stab_d = '0; m_edge = '0; m_mask = '0;
        m_per = 16'd50000; m_rd = '0; m_irq = 1'b0;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
    endtask

    // Advance one clock; the model consumes the inputs that the DUT samples on this edge.
    task automatic step();
        logic [31:0] n_rd;
        logic [2:0]  clr, n_stab, pins;
        logic [31:0] wd;
        logic [1:0]  a;
        logic        wr;
        int          n_run [3];
        wr = chipselect && write;
        a = address;
        wd = writedata;
        pins = in_port;
        case (a)
            2'd0:    n_rd = {29'd0, m_stab};
            2'd1:    n_rd = {29'd0, m_mask};
            2'd2:    n_rd = {29'd0, m_edge};
            default: n_rd = {16'd0, m_per};
        endcase
        clr = (wr && a == 2'd2) ? wd[2:0] : 3'b000;
        n_stab = m_stab;
        for (int i = 0; i < 3; i++) begin
            if (m_per == 16'd0) begin
                n_stab[i] = m_s2[i];
                n_run[i] = 0;
            end else if (wr && a == 2'd3) begin
                n_run[i] = 0;
            end else if (m_s2[i] != m_stab[i]) begin
                n_run[i] = m_run[i] + 1;
                if (n_run[i] >= int'(m_per)) begin
                    n_stab[i] = m_s2[i];
                    n_run[i] = 0;
                end
            end else begin
                n_run[i] = 0;
            end
        end
        @(posedge clk);
        #1;
        m_irq = |(m_edge & m_mask);
        m_edge = (m_edge & ~clr) | (m_stab ^ m_stab_d);
        m_stab_d = m_stab;
        m_stab = n_stab;
        m_run = n_run;
        m_s2 = m_s1;
        m_s1 = pins;
        if (wr && a == 2'd1) m_mask = wd[2:0];
        if (wr && a == 2'd3) m_per = wd[15:0];
        m_rd = n_rd;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        step();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic test_reset();
        int exp_rst [4];
        exp_rst = '{0, 0, 0, 50000};
        in_port = 3'b000;
        reset_n = 1'b0;
        #3;
        m_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            step();
            checks++;
            if (readdata !== 32'(exp_rst[a])) begin
                errors++;
                $display("[TB] FAIL reset_read addr=%0d actual=%0d required=%0d", a, readdata, exp_rst[a]);
            end
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_irq actual=%b required=0", irq);
            end
        end
    endtask

    task automatic test_debounce();
        int first_data = 0;
        int first_irq = 0;
        write_reg(2'd3, 32'd4);
        write_reg(2'd1, 32'd1);
        address = 2'd0;
        in_port = 3'b001;
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++;
            if (readdata !== m_rd || irq !== m_irq) begin
                errors++;
                $display("[TB] FAIL debounce_model cyc=%0d actual rd=%h irq=%b required rd=%h irq=%b",
                         k, readdata, irq, m_rd, m_irq);
            end
            if (first_data == 0 && readdata[0] === 1'b1) first_data = k;
            if (first_irq == 0 && irq === 1'b1) first_irq = k;
        end
        checks++;
        if (first_data != 7) begin
            errors++;
            $display("[TB] FAIL debounce_data_latency actual=%0d required=7", first_data);
        end
        checks++;
        if (first_irq != 8) begin
            errors++;
            $display("[TB] FAIL debounce_irq_latency actual=%0d required=8", first_irq);
        end
        address = 2'd2;
        step();
        checks++;
        if (readdata !== 32'd1) begin
            errors++;
            $display("[TB] FAIL debounce_edge actual=%h required=1", readdata);
        end
    endtask

    task automatic test_glitch();
        write_reg(2'd2, 32'h7);
        address = 2'd0;
        step();
        step();
        in_port = 3'b011;
        for (int k = 0; k < 14; k++) begin
            if (k == 3) in_port = 3'b001;
            step();
            checks++;
            if (readdata !== m_rd || readdata[1] !== 1'b0 || irq !== 1'b0) begin
                errors++;
                $display("[TB] FAIL glitch cyc=%0d actual rd=%h irq=%b required rd=%h irq=0",
                         k, readdata, irq, m_rd);
            end
        end
        address = 2'd2;
        step();
        checks++;
        if (readdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL glitch_edge actual=%h required=0", readdata);
        end
    endtask

    task automatic test_w1c();
        write_reg(2'd1, 32'h3);
        in_port = 3'b010;
        address = 2'd2;
        for (int k = 0; k < 10; k++) step();
        checks++;
        if (readdata !== 32'd3 || irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL w1c_pending actual edge=%h irq=%b required edge=3 irq=1", readdata, irq);
        end
        write_reg(2'd2, 32'h1);
        address = 2'd2;
        step();
        checks++;
        if (readdata !== 32'd2 || irq !== 1'b1 || readdata !== m_rd) begin
            errors++;
            $display("[TB] FAIL w1c_partial actual edge=%h irq=%b required edge=2 irq=1", readdata, irq);
        end
        write_reg(2'd2, 32'h2);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL w1c_irq_hold actual=%b required=1", irq);
        end
        address = 2'd2;
        step();
        checks++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL w1c_clear actual edge=%h irq=%b required edge=0 irq=0", readdata, irq);
        end
    endtask

    task automatic test_bypass();
        int lat;
        logic want;
        write_reg(2'd3, 32'd0);
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 4; k++) step();
            write_reg(2'd2, 32'h7);
            address = 2'd0;
            step();
            in_port[2] = ~in_port[2];
            want = in_port[2];
            lat = 0;
            for (int k = 1; k <= 8; k++) begin
                step();
                if (lat == 0 && readdata[2] === want) lat = k;
            end
            checks++;
            if (lat != 4) begin
                errors++;
                $display("[TB] FAIL bypass_latency toggle=%0d actual=%0d required=4", t, lat);
            end
            address = 2'd2;
            step();
            checks++;
            if (readdata[2] !== 1'b1 || readdata !== m_rd) begin
                errors++;
                $display("[TB] FAIL bypass_edge toggle=%0d actual=%h required=%h", t, readdata, m_rd);
            end
        end
    endtask

    task automatic test_same_cycle();
        write_reg(2'd2, 32'h7);
        for (int k = 0; k < 5; k++) step();
        write_reg(2'd2, 32'h7);
        step();
        in_port[0] = ~in_port[0];
        step();
        step();
        step();
        write_reg(2'd2, 32'h1);
        address = 2'd2;
        step();
        checks++;
        if (readdata[0] !== 1'b1 || readdata !== m_rd) begin
            errors++;
            $display("[TB] FAIL same_cycle_set_wins actual=%h required=%h", readdata, m_rd);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) in_port = 3'($urandom);
            address = 2'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                chipselect = 1'b1;
                write = 1'($urandom);
                writedata = (address == 2'd3) ? ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 5))
                                              : $urandom;
            end else begin
                chipselect = 1'($urandom);
                write = 1'b0;
                writedata = $urandom;
            end
            step();
            checks++;
            if (readdata !== m_rd || irq !== m_irq) begin
                errors++;
                $display("[TB] FAIL random cyc=%0d actual rd=%h irq=%b required rd=%h irq=%b",
                         k, readdata, irq, m_rd, m_irq);
            end
        end
        chipselect = 1'b0;
        write = 1'b0;
    endtask

    task automatic test_reset_mid();
        int exp_rst [4];
        exp_rst = '{0, 0, 0, 50000};
        write_reg(2'd1, 32'h7);
        write_reg(2'd3, 32'd4);
        address = 2'd3;
        in_port[2] = ~in_port[2];
        for (int k = 0; k < 4; k++) step();
        reset_n = 1'b0;
        #2;
        checks++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async actual rd=%h irq=%b required rd=0 irq=0", readdata, irq);
        end
        m_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            step();
            checks++;
            if (readdata !== 32'(exp_rst[a]) || irq !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_mid addr=%0d actual rd=%0d irq=%b required rd=%0d irq=0",
                         a, readdata, irq, exp_rst[a]);
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_debounce();
        test_glitch();
        test_w1c();
        test_bypass();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wasca_switches_ctrl.md
Name: wasca_switches_ctrl

Overview:
- Avalon-MM slave controller for the board switch inputs; replaces raw PIO sampling with synchronised, debounced switch state.
- Adds per-bit change (edge) capture, an interrupt mask and a programmable debounce period.
- Sits between the switch pins and the Nios II / Saturn-side host.
- Fixed read latency of 1 clock.

Parameters:
- WIDTH, 3, number of switch inputs (1..32).
- DEBOUNCE_RST, 50000, reset value of debounce period register in clk cycles (1 ms at 50 MHz).
- CNT_W, 16, width of debounce period register and per-bit counters.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  register word select.
- chipselect  in  1  slave select.
- write  in  1  write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  raw asynchronous switch pins.
- irq  out  1  level interrupt, active high.

Behaviour:
- Reset and clock: reset reset_n, asynchronous, active-low; clock clk.
- Register map:
  - 0 DATA (RO): debounced state in [WIDTH-1:0], upper bits 0.
  - 1 IRQ_MASK (RW): [WIDTH-1:0], reset 0.
  - 2 EDGE (W1C): captured changes, reset 0.
  - 3 PERIOD (RW): [CNT_W-1:0], reset DEBOUNCE_RST.
- Reset values: readdata=0, irq=0, sync regs=0, stable=0, counters=0, edge=0, mask=0, period=DEBOUNCE_RST.
  - A switch high at reset is therefore reported as a 0->1 change after debounce. This is intended.
- Synchroniser: 2-FF per bit. sync = in_port delayed 2 clocks.
- Debounce, per bit i, independent counters:
  - If sync[i]==stable[i]: cnt[i] <= 0.
  - Else if cnt[i]==period-1: stable[i] <= sync[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - stable[i] updates P clocks after sync[i] first differs, provided the value holds for P consecutive cycles.
  - Any glitch shorter than P cycles resets the count; stable does not change.
  - Total pin-to-DATA latency is 2+P clocks.
- PERIOD==0 means bypass: stable <= sync every cycle, counters held at 0.
- A write to PERIOD clears all counters in the same cycle. A debounce in progress restarts with the new period.
- Edge capture:
  - stable_d = stable delayed 1 clock.
  - edge[i] <= 1 when stable[i]^stable_d[i]. This covers both polarities.
  - Edge bit is visible 1 clock after stable changes.
- EDGE clear: write to address 2 with writedata[i]=1 clears edge[i]; 0 bits are unaffected.
  - If a set and a clear occur in the same cycle, set wins.
- IRQ_MASK / PERIOD writes take effect on the next clock. Writes to DATA are ignored.
- irq: registered; irq <= |(edge & mask). It follows edge/mask changes with 1 clock delay and deasserts 1 clock after the clearing write.
- readdata:
  - Each cycle, readdata <= zero-extended mux(address) of the current register values.
  - Reads have no side effects.
  - A value written in cycle N is readable in readdata at N+2 when address is held.
- Width rules: writedata bits above WIDTH (mask/edge) or CNT_W (period) are ignored and read back 0.
- Reset asserted mid-debounce or with edge pending: all state returns to reset values immediately. No irq glitch after release.

Test Plan:
- Reset with in_port=3'b000; read all four addresses -> 0, 0, 0, 50000 (0xC350); irq=0.
- Write PERIOD=4, MASK=3'b001. Set in_port=3'b001 and hold -> DATA=1 six clocks after pin change. EDGE=1 one clock later. irq=1 one clock after that.
- PERIOD=4, in_port[1] pulses high for 3 clocks, then low -> DATA[1] stays 0, EDGE[1] stays 0, irq stays 0.
- With EDGE=3'b011 pending and MASK=3'b011, write EDGE=3'b001 -> EDGE reads 3'b010 and irq stays 1. Then write 3'b010 -> EDGE=0 and irq=0 one clock later.
- PERIOD=0 bypass: in_port toggles bit 2 -> DATA[2] follows exactly 3 clocks after the pin (2 sync + 1 register). Every toggle sets EDGE[2], including both polarities.
- Same-cycle event: a stable change on bit 0 coincides with a W1C of bit 0 -> EDGE[0]=1 remains. Separately, assert reset_n=0 mid-count with PERIOD=4 -> all registers return to reset values and irq=0.
